// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings and serial line levels.
package uart_pkg;

  // Receiver FSM states. PARITY is only entered when parity checking is built in.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_t;

  // Level of an idle line (and of a valid stop bit).
  localparam logic LINE_IDLE   = 1'b1;
  // Level of a start bit.
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous serial line. Both flops reset to
// the idle line level so that reset never looks like a start bit downstream.
module uart_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  // Shift the raw line through two flops; only the second is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= LINE_IDLE;
      sync_reg <= LINE_IDLE;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, DATA_BITS data bits LSB first, optional even
// parity, 1 stop bit. Bits are sampled at mid-bit; received words are offered
// through a valid/read handshake with overrun and framing flags.
// Build option: define UART_RX_PARITY_EN to insert an even-parity bit check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE     = 50000000,
  parameter int BAUD_RATE      = 9600,
  parameter int DATA_BITS      = 8,
  parameter int CYCLES_PER_BIT = CLOCK_RATE / BAUD_RATE
)
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  input  logic                 i_read,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_busy,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_parity_err
);

  localparam int CNT_W = $clog2(CYCLES_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  // Loading N-1 gives an N-cycle period ending on the cycle the counter is 0.
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [DATA_BITS-1:0] word_reg, word_next;
  logic [DATA_BITS-1:0] data_reg;
  logic                 valid_reg, frame_err_reg, overrun_reg;
  logic                 cnt_zero;
  logic                 deliver;
  logic                 frame_bad;
  logic                 parity_bad;

  uart_sync u_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (i_rx),
    .q     (rx_s)
  );

  assign cnt_zero = (cnt_reg == '0);

`ifdef UART_RX_PARITY_EN
  logic par_reg, par_next;
  logic parity_err_reg;
  // Even parity: the received parity bit must equal the XOR of the data bits.
  assign parity_bad = deliver && ((^word_reg) != par_reg);
`else
  assign parity_bad = 1'b0;
`endif

  // Next-state logic: bit timing, data assembly and frame checks.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_zero ? cnt_reg : cnt_reg - CNT_W'(1);
    idx_next   = idx_reg;
    word_next  = word_reg;
`ifdef UART_RX_PARITY_EN
    par_next   = par_reg;
`endif
    deliver    = 1'b0;
    frame_bad  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (rx_s == START_LEVEL) begin
          cnt_next   = HALF_LOAD;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (cnt_zero) begin
          if (rx_s == START_LEVEL) begin
            cnt_next   = FULL_LOAD;
            idx_next   = '0;
            state_next = ST_DATA;
          end else begin
            // Start edge was a glitch: drop back silently.
            state_next = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (cnt_zero) begin
          // Shift in from the MSB side so the first bit ends up at bit 0.
          word_next = {rx_s, word_reg[DATA_BITS-1:1]};
          cnt_next  = FULL_LOAD;
          idx_next  = idx_reg + IDX_W'(1);
          if (idx_reg == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_zero) begin
          par_next   = rx_s;
          cnt_next   = FULL_LOAD;
          state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_zero) begin
          // Leave at mid-stop-bit so a following start edge is not missed.
          if (rx_s == LINE_IDLE) begin
            deliver    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            frame_bad  = 1'b1;
            state_next = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        // A held-low line (break) must not be mistaken for a new start bit.
        if (rx_s == LINE_IDLE) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      word_reg  <= '0;
`ifdef UART_RX_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      word_reg  <= word_next;
`ifdef UART_RX_PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

  // Output handshake: a delivery beats a coincident read; overrun is sticky.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= frame_bad;
      if (deliver) begin
        data_reg  <= word_reg;
        valid_reg <= 1'b1;
        if (valid_reg) begin
          overrun_reg <= !i_read;
        end
      end else if (i_read && valid_reg) begin
        valid_reg   <= 1'b0;
        overrun_reg <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error pulse, aligned with the delivery of the affected word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      parity_err_reg <= 1'b0;
    end else begin
      parity_err_reg <= parity_bad;
    end
  end
  assign o_parity_err = parity_err_reg;
`else
  assign o_parity_err = parity_bad;
`endif

  assign o_data      = data_reg;
  assign o_valid     = valid_reg;
  assign o_busy      = (state_reg != ST_IDLE);
  assign o_frame_err = frame_err_reg;
  assign o_overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with C=10 clocks per bit and 8 data bits.
// Expected words are queued when a frame is driven and popped on delivery.
module tb_uart_rx;

  localparam int C = 10;
`ifdef UART_RX_PARITY_EN
  localparam int L = 108;
`else
  localparam int L = 98;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] o_data;
  logic       o_valid, o_busy, o_frame_err, o_overrun, o_parity_err;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb_q[$];

  uart_rx #(
    .CLOCK_RATE (1000000),
    .BAUD_RATE  (100000),
    .DATA_BITS  (8)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx         (rx),
    .i_read       (rd),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_busy       (o_busy),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun),
    .o_parity_err (o_parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  // Drive one line level for a number of cycles, starting just after an edge.
  task automatic line_bit(input logic b, input int cycles);
    #1 rx = b;
    repeat (cycles) @(posedge clk);
  endtask

  // Drive a good-stop frame and check the delivery at its exact latency.
  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic read_at_dlv);
    logic exp_perr;
    logic prev_valid;
    logic prev_overrun;
    logic exp_ovr;
    logic [7:0] exp;
`ifdef UART_RX_PARITY_EN
    exp_perr = ((^d) != par_bit);
`else
    exp_perr = 1'b0;
`endif
    prev_valid = 1'b0;
    prev_overrun = 1'b0;
    sb_q.push_back(d);
    fork
      begin
        line_bit(1'b0, C);
        for (int i = 0; i < 8; i++) line_bit(d[i], C);
`ifdef UART_RX_PARITY_EN
        line_bit(par_bit, C);
`endif
        line_bit(1'b1, C);
      end
      begin
        for (int n = 1; n <= L + 1; n++) begin
          @(posedge clk);
          #1;
          if (n == L - 1) begin
            checks++;
            if (o_busy !== 1'b1) begin
              failures++;
              $display("FAIL busy_before_delivery: got %0b want 1", o_busy);
            end
            prev_valid = o_valid;
            prev_overrun = o_overrun;
            if (read_at_dlv) rd = 1'b1;
          end
          if (n == L) begin
            rd = 1'b0;
            exp_ovr = read_at_dlv ? 1'b0 : (prev_overrun | prev_valid);
            checks++;
            if (sb_q.size() == 0) begin
              failures++;
              $display("FAIL scoreboard_empty: got delivery %02h want none", o_data);
              exp = 8'h00;
            end else begin
              exp = sb_q.pop_front();
            end
            $display("frame %02h: o_data=%02h o_valid=%0b o_overrun=%0b o_parity_err=%0b cycle %0d",
                     d, o_data, o_valid, o_overrun, o_parity_err, n);
            checks++;
            if (o_data !== exp) begin
              failures++;
              $display("FAIL data: got %02h want %02h", o_data, exp);
            end
            checks++;
            if (o_valid !== 1'b1) begin
              failures++;
              $display("FAIL valid_at_latency: got %0b want 1", o_valid);
            end
            checks++;
            if (o_busy !== 1'b0) begin
              failures++;
              $display("FAIL busy_at_delivery: got %0b want 0", o_busy);
            end
            checks++;
            if ({o_frame_err, o_parity_err, o_overrun} !== {1'b0, exp_perr, exp_ovr}) begin
              failures++;
              $display("FAIL flags_at_delivery: got fe=%0b pe=%0b ov=%0b want fe=0 pe=%0b ov=%0b",
                       o_frame_err, o_parity_err, o_overrun, exp_perr, exp_ovr);
            end
          end
          if (n == L + 1) begin
            checks++;
            if ({o_frame_err, o_parity_err} !== 2'b00) begin
              failures++;
              $display("FAIL pulse_width: got fe=%0b pe=%0b want 0 0", o_frame_err, o_parity_err);
            end
          end
        end
      end
    join
  endtask

  // Acknowledge the current word; then show a read with nothing pending is ignored.
  task automatic do_read();
    logic [7:0] held;
    #1 rd = 1'b1;
    @(posedge clk);
    #1 rd = 1'b0;
    checks++;
    if ({o_valid, o_overrun} !== 2'b00) begin
      failures++;
      $display("FAIL read_clears: got valid=%0b overrun=%0b want 0 0", o_valid, o_overrun);
    end
    held = o_data;
    rd = 1'b1;
    @(posedge clk);
    #1 rd = 1'b0;
    checks++;
    if ({o_valid, o_overrun, o_data} !== {2'b00, held}) begin
      failures++;
      $display("FAIL idle_read: got valid=%0b overrun=%0b data=%02h want 0 0 %02h",
               o_valid, o_overrun, o_data, held);
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_data, o_valid, o_busy, o_frame_err, o_overrun, o_parity_err} !== 13'b0) begin
      failures++;
      $display("FAIL reset_outputs: got data=%02h v=%0b b=%0b fe=%0b ov=%0b pe=%0b want all 0",
               o_data, o_valid, o_busy, o_frame_err, o_overrun, o_parity_err);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_valid, o_busy, o_frame_err, o_overrun} !== 4'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got v=%0b b=%0b fe=%0b ov=%0b want 0",
               o_valid, o_busy, o_frame_err, o_overrun);
    end
    @(posedge clk);
  endtask

  task automatic test_clean_frame();
    send_frame(8'hA5, ^8'hA5, 1'b0);
    do_read();
  endtask

  task automatic test_glitch();
    int bad;
    bad = 0;
    fork
      begin
        line_bit(1'b0, 3);
        line_bit(1'b1, 17);
      end
      begin
        for (int n = 1; n <= 20; n++) begin
          @(posedge clk);
          #1;
          if (o_valid || o_frame_err || o_overrun) bad++;
          if (n == 7) begin
            checks++;
            if (o_busy !== 1'b1) begin
              failures++;
              $display("FAIL glitch_busy_high: got %0b want 1", o_busy);
            end
          end
          if (n == 8) begin
            checks++;
            if (o_busy !== 1'b0) begin
              failures++;
              $display("FAIL glitch_busy_low: got %0b want 0", o_busy);
            end
          end
        end
      end
    join
    $display("glitch: start sample rejected");
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL glitch_flags: got %0d flagged cycles want 0", bad);
    end
  endtask

  task automatic test_frame_error();
    logic [7:0] d;
    int fe_pulses;
    int valid_seen;
    d = 8'h3C;
    fe_pulses = 0;
    valid_seen = 0;
    fork
      begin
        line_bit(1'b0, C);
        for (int i = 0; i < 8; i++) line_bit(d[i], C);
`ifdef UART_RX_PARITY_EN
        line_bit(^d, C);
        line_bit(1'b0, 20);
`else
        line_bit(1'b0, 30);
`endif
        line_bit(1'b1, 10);
      end
      begin
        for (int n = 1; n <= 130; n++) begin
          @(posedge clk);
          #1;
          if (o_frame_err) fe_pulses++;
          if (o_valid) valid_seen++;
          if (n == L) begin
            checks++;
            if (o_frame_err !== 1'b1) begin
              failures++;
              $display("FAIL frame_err_pulse: got %0b want 1", o_frame_err);
            end
          end
          if (n == 110) begin
            checks++;
            if (o_busy !== 1'b1) begin
              failures++;
              $display("FAIL wait_high_busy: got %0b want 1", o_busy);
            end
          end
          if (n == 126) begin
            checks++;
            if (o_busy !== 1'b0) begin
              failures++;
              $display("FAIL wait_high_release: got %0b want 0", o_busy);
            end
          end
        end
      end
    join
    $display("frame %02h: stop bit low, frame_err pulses=%0d", d, fe_pulses);
    checks++;
    if ({fe_pulses, valid_seen} !== {32'd1, 32'd0}) begin
      failures++;
      $display("FAIL frame_err_count: got pulses=%0d valid_cycles=%0d want 1 0", fe_pulses, valid_seen);
    end
    send_frame(8'h55, ^8'h55, 1'b0);
    do_read();
  endtask

  task automatic test_overrun();
    send_frame(8'h11, ^8'h11, 1'b0);
    send_frame(8'h22, ^8'h22, 1'b0);
    do_read();
  endtask

  task automatic test_read_collision();
    send_frame(8'h33, ^8'h33, 1'b0);
    send_frame(8'h44, ^8'h44, 1'b1);
    do_read();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'hF0;
    line_bit(1'b0, C);
    for (int i = 0; i < 4; i++) line_bit(d[i], C);
    line_bit(d[4], 5);
    #1;
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_mid_frame: got %0b want 1", o_busy);
    end
    rst_n = 1'b0;
    #1;
    $display("reset asserted during data bit 4 of %02h", d);
    checks++;
    if ({o_data, o_valid, o_busy, o_frame_err, o_overrun, o_parity_err} !== 13'b0) begin
      failures++;
      $display("FAIL async_reset: got data=%02h v=%0b b=%0b fe=%0b ov=%0b pe=%0b want all 0",
               o_data, o_valid, o_busy, o_frame_err, o_overrun, o_parity_err);
    end
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if ({o_valid, o_busy, o_frame_err, o_overrun} !== 4'b0) begin
      failures++;
      $display("FAIL after_abort: got v=%0b b=%0b fe=%0b ov=%0b want 0",
               o_valid, o_busy, o_frame_err, o_overrun);
    end
    @(posedge clk);
    send_frame(8'h0F, ^8'h0F, 1'b0);
    do_read();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h07, 1'b0, 1'b0);
    do_read();
    send_frame(8'h07, 1'b1, 1'b0);
    do_read();
  endtask
`endif

  initial begin
    test_reset();
    test_clean_frame();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_read_collision();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: got %0d words want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
